// File: rtl/prog_rom_rx.sv
// Program store for the edit/unit/code/send loader: timed clear sweep, edge-strobed byte
// writes, and a four-lane registered instruction fetch. Define PROG_ROM_READBACK_EN for rd_data.
module prog_rom_rx #(
  parameter int                 ADDR_W = 8,
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0]  FILL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstROM,
  input  logic              edit,
  input  logic [ADDR_W-1:0] unit,
  input  logic [DATA_W-1:0] code,
  input  logic              send,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr0,
  output logic [DATA_W-1:0] instr1,
  output logic [DATA_W-1:0] instr2,
  output logic [DATA_W-1:0] instr3,
  output logic              ready,
  output logic              wr_ack,
`ifdef PROG_ROM_READBACK_EN
  output logic [DATA_W-1:0] rd_data,
`endif
  output logic [ADDR_W:0]   wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_addr;
  logic                send_q;
  logic                clr_req;
  logic                commit;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   lane_addr [4];
  logic [DATA_W-1:0]   instr_q   [4];
  logic [DATA_W-1:0]   mem       [DEPTH];

  // rst and rstROM are interchangeable and both outrank a same-edge write.
  assign clr_req = rst | rstROM;
  assign commit  = send & ~send_q & edit & (state == IDLE) & ~clr_req;

  // State register
  always_ff @(posedge clk) begin
    if (clr_req) state <= CLEAR;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    state_next = state;
    case (state)
      CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = IDLE;
      IDLE:    state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr_req) begin
      clr_addr <= '0;
      send_q   <= 1'b0;
      wr_ack   <= 1'b0;
      wr_count <= '0;
    end else begin
      send_q <= send;
      wr_ack <= commit;
      if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
      if (commit && wr_count != {CNT_W{1'b1}}) wr_count <= wr_count + CNT_W'(1);
    end
  end

  // One write port shared by the clear sweep and loader commits.
  always_comb begin
    wr_en   = (state == CLEAR) | commit;
    wr_addr = (state == CLEAR) ? clr_addr : unit;
    wr_data = (state == CLEAR) ? FILL : code;
  end

  // NOTE: the array has no reset; contents are initialised by the clear sweep instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) lane_addr[i] = pc + ADDR_W'(i);
  end

  // Lanes that hit the address being committed return the new byte (write-first).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (clr_req || state == CLEAR)             instr_q[i] <= '0;
      else if (commit && lane_addr[i] == unit)   instr_q[i] <= code;
      else                                       instr_q[i] <= mem[lane_addr[i]];
    end
  end

  assign instr0 = instr_q[0];
  assign instr1 = instr_q[1];
  assign instr2 = instr_q[2];
  assign instr3 = instr_q[3];

`ifdef PROG_ROM_READBACK_EN
  always_ff @(posedge clk) begin
    if (clr_req || state == CLEAR || !edit) rd_data <= '0;
    else if (commit)                        rd_data <= code;
    else                                    rd_data <= mem[unit];
  end
`endif

endmodule
